// File: rtl/riscv_run_monitor.sv
// Run controller and statistics monitor for a 5-stage RISC-V pipeline.
// Holds the core in reset, counts run-time events, and ends the run on halt or cycle budget.
module riscv_run_monitor #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 10,
  parameter int HALT_WINDOW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc_ex,
  input  logic [XLEN-1:0]  pc_mem,
  input  logic             pcsrc,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic             pipeline_stall,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] fwd_a_count,
  output logic [CNT_W-1:0] fwd_b_count,
  output logic [CNT_W-1:0] branch_count,
  output logic [XLEN-1:0]  last_pc
);

  localparam int SW  = $clog2(HALT_WINDOW + 1);
  localparam int RCW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {RST_CORE, RUN, DONE_S} state_t;

  // Current FSM state; visible hierarchically for checkers.
  state_t          state;
  logic [RCW-1:0]  rst_cnt;
  logic [XLEN-1:0] prev_pc;
  logic            prev_valid;
  logic [SW-1:0]   stable_cnt;

  logic [CNT_W-1:0] cyc_next, stall_next, fwd_a_next, fwd_b_next, branch_next;
  logic [SW-1:0]    stable_next;
  logic             halt_hit, time_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
    return (ev && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    cyc_next    = sat_inc(cycle_count, 1'b1);
    stall_next  = sat_inc(stall_count, pipeline_stall);
    fwd_a_next  = sat_inc(fwd_a_count, forward_a != 2'd0);
    fwd_b_next  = sat_inc(fwd_b_count, forward_b != 2'd0);
    branch_next = sat_inc(branch_count, pcsrc);
    // A stalled or redirected PC is never evidence of a halt.
    if (prev_valid && (pc_ex == prev_pc) && !pipeline_stall && !pcsrc)
      stable_next = stable_cnt + SW'(1);
    else
      stable_next = '0;
    halt_hit = (stable_next == SW'(HALT_WINDOW));
    time_hit = (cyc_next == CNT_W'(MAX_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RST_CORE;
      rst_cnt      <= RCW'(RESET_CYCLES);
      core_reset   <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      stall_count  <= '0;
      fwd_a_count  <= '0;
      fwd_b_count  <= '0;
      branch_count <= '0;
      last_pc      <= '0;
      prev_pc      <= '0;
      prev_valid   <= 1'b0;
      stable_cnt   <= '0;
    end else begin
      case (state)
        RST_CORE: begin
          if (rst_cnt <= RCW'(1)) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
            prev_valid <= 1'b0;
            stable_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt - RCW'(1);
          end
        end
        RUN: begin
          cycle_count  <= cyc_next;
          stall_count  <= stall_next;
          fwd_a_count  <= fwd_a_next;
          fwd_b_count  <= fwd_b_next;
          branch_count <= branch_next;
          prev_pc      <= pc_ex;
          prev_valid   <= 1'b1;
          stable_cnt   <= stable_next;
          if (halt_hit || time_hit) begin
            state   <= DONE_S;
            done    <= 1'b1;
            running <= 1'b0;
            halted  <= halt_hit;
            timeout <= time_hit;
            last_pc <= pc_mem;
          end
        end
        DONE_S: ;
        default: state <= RST_CORE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Directed self-checking bench for riscv_run_monitor (default instance plus a narrow-counter instance).
module tb_riscv_run_monitor;

  logic        clk;
  logic        reset;
  logic [31:0] pc_ex, pc_mem;
  logic        pcsrc, pipeline_stall;
  logic [1:0]  forward_a, forward_b;

  logic        core_reset, running, done, halted, timeout;
  logic [15:0] cycle_count, stall_count, fwd_a_count, fwd_b_count, branch_count;
  logic [31:0] last_pc;

  logic        core_reset2, running2, done2, halted2, timeout2;
  logic [2:0]  cycle_count2, stall_count2, fwd_a_count2, fwd_b_count2, branch_count2;
  logic [31:0] last_pc2;

  int checks = 0;
  int errors = 0;

  riscv_run_monitor dut (
    .clk(clk), .reset(reset), .pc_ex(pc_ex), .pc_mem(pc_mem), .pcsrc(pcsrc),
    .forward_a(forward_a), .forward_b(forward_b), .pipeline_stall(pipeline_stall),
    .core_reset(core_reset), .running(running), .done(done), .halted(halted),
    .timeout(timeout), .cycle_count(cycle_count), .stall_count(stall_count),
    .fwd_a_count(fwd_a_count), .fwd_b_count(fwd_b_count),
    .branch_count(branch_count), .last_pc(last_pc)
  );

  riscv_run_monitor #(.CNT_W(3), .MAX_CYCLES(7)) dut2 (
    .clk(clk), .reset(reset), .pc_ex(pc_ex), .pc_mem(pc_mem), .pcsrc(pcsrc),
    .forward_a(forward_a), .forward_b(forward_b), .pipeline_stall(pipeline_stall),
    .core_reset(core_reset2), .running(running2), .done(done2), .halted(halted2),
    .timeout(timeout2), .cycle_count(cycle_count2), .stall_count(stall_count2),
    .fwd_a_count(fwd_a_count2), .fwd_b_count(fwd_b_count2),
    .branch_count(branch_count2), .last_pc(last_pc2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_ex = '0; pc_mem = '0; pcsrc = 0; pipeline_stall = 0; forward_a = 0; forward_b = 0;
  endtask

  task automatic start_run();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    checks++;
    if ({core_reset, running, done, halted, timeout} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 10000", {core_reset, running, done, halted, timeout});
    end
    checks++;
    if ({cycle_count, stall_count, fwd_a_count, fwd_b_count, branch_count} !== 80'd0 || last_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters got %0h/%0h/%0h/%0h/%0h pc %0h exp 0",
               cycle_count, stall_count, fwd_a_count, fwd_b_count, branch_count, last_pc);
    end
    reset = 0;
    #3;
    checks++;
    if (core_reset !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_hold got core_reset=%b running=%b exp 1/0", core_reset, running);
    end
    step();
    checks++;
    if (core_reset !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL run_entry got core_reset=%b running=%b exp 0/1", core_reset, running);
    end
  endtask

  task automatic test_timeout();
    start_run();
    for (int i = 1; i <= 10; i++) begin
      pc_ex = 32'h100 + 32'(4 * i);
      pc_mem = pc_ex - 32'd8;
      step();
      if (i == 9) begin
        checks++;
        if (done !== 1'b0 || cycle_count !== 16'd9) begin
          errors++;
          $display("FAIL timeout_early got done=%b cycles=%0d exp 0/9", done, cycle_count);
        end
      end
    end
    checks++;
    if ({done, timeout, halted, running} !== 4'b1100) begin
      errors++;
      $display("FAIL timeout_flags got %b exp 1100", {done, timeout, halted, running});
    end
    checks++;
    if (cycle_count !== 16'd10 || stall_count !== 0 || fwd_a_count !== 0 || fwd_b_count !== 0 || branch_count !== 0) begin
      errors++;
      $display("FAIL timeout_counts got %0d/%0d/%0d/%0d/%0d exp 10/0/0/0/0",
               cycle_count, stall_count, fwd_a_count, fwd_b_count, branch_count);
    end
    checks++;
    if (last_pc !== 32'h120) begin
      errors++;
      $display("FAIL timeout_last_pc got %0h exp 120", last_pc);
    end
  endtask

  task automatic test_events();
    start_run();
    for (int i = 1; i <= 10; i++) begin
      pc_ex = 32'h400 + 32'(4 * i);
      pipeline_stall = (i <= 3);
      forward_a = (i == 4 || i == 5) ? 2'd2 : 2'd0;
      forward_b = (i == 6) ? 2'd1 : 2'd0;
      pcsrc = (i == 7);
      step();
    end
    idle_inputs();
    checks++;
    if (stall_count !== 16'd3 || fwd_a_count !== 16'd2 || fwd_b_count !== 16'd1 || branch_count !== 16'd1) begin
      errors++;
      $display("FAIL event_counts got %0d/%0d/%0d/%0d exp 3/2/1/1",
               stall_count, fwd_a_count, fwd_b_count, branch_count);
    end
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || cycle_count !== 16'd10) begin
      errors++;
      $display("FAIL event_done got done=%b timeout=%b cycles=%0d exp 1/1/10", done, timeout, cycle_count);
    end
  endtask

  task automatic test_halt();
    start_run();
    for (int i = 1; i <= 6; i++) begin
      pc_ex = (i == 1) ? 32'h1c : 32'h20;
      pc_mem = 32'h1000 + 32'(4 * i);
      step();
      if (i == 5) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL halt_early got done=%b exp 0", done);
        end
      end
    end
    checks++;
    if ({done, halted, timeout, running} !== 4'b1100 || cycle_count !== 16'd6) begin
      errors++;
      $display("FAIL halt_flags got %b cycles=%0d exp 1100/6", {done, halted, timeout, running}, cycle_count);
    end
    checks++;
    if (last_pc !== 32'h1018) begin
      errors++;
      $display("FAIL halt_last_pc got %0h exp 1018", last_pc);
    end
    // inputs after the run must not move anything
    pipeline_stall = 1; pcsrc = 1; forward_a = 2'd1; pc_mem = 32'hdead;
    repeat (3) step();
    idle_inputs();
    checks++;
    if (cycle_count !== 16'd6 || stall_count !== 0 || branch_count !== 0 || fwd_a_count !== 0 ||
        last_pc !== 32'h1018 || done !== 1'b1 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL done_frozen got cyc=%0d stall=%0d br=%0d fa=%0d pc=%0h done=%b cr=%b exp 6/0/0/0/1018/1/0",
               cycle_count, stall_count, branch_count, fwd_a_count, last_pc, done, core_reset);
    end
  endtask

  task automatic test_stalled_pc();
    start_run();
    pc_ex = 32'h20;
    pipeline_stall = 1;
    repeat (10) step();
    idle_inputs();
    checks++;
    if ({done, timeout, halted} !== 3'b110 || stall_count !== 16'd10 || cycle_count !== 16'd10) begin
      errors++;
      $display("FAIL stall_no_halt got %b stall=%0d cyc=%0d exp 110/10/10",
               {done, timeout, halted}, stall_count, cycle_count);
    end
    checks++;
    if ({done2, timeout2, halted2} !== 3'b110 || stall_count2 !== 3'd7 || cycle_count2 !== 3'd7) begin
      errors++;
      $display("FAIL narrow_saturate got %b stall=%0d cyc=%0d exp 110/7/7",
               {done2, timeout2, halted2}, stall_count2, cycle_count2);
    end
  endtask

  task automatic test_halt_and_timeout();
    start_run();
    for (int i = 1; i <= 10; i++) begin
      pc_ex = (i <= 5) ? 32'h200 + 32'(4 * i) : 32'h300;
      pc_mem = 32'h2000 + 32'(i);
      step();
    end
    idle_inputs();
    checks++;
    if ({done, halted, timeout} !== 3'b111 || cycle_count !== 16'd10 || last_pc !== 32'h200a) begin
      errors++;
      $display("FAIL halt_and_timeout got %b cyc=%0d pc=%0h exp 111/10/200a",
               {done, halted, timeout}, cycle_count, last_pc);
    end
  endtask

  task automatic test_mid_run_reset();
    start_run();
    for (int i = 1; i <= 5; i++) begin
      pc_ex = 32'h80 + 32'(4 * i);
      pipeline_stall = 1;
      forward_b = 2'd3;
      step();
    end
    checks++;
    if (cycle_count !== 16'd5 || stall_count !== 16'd5 || fwd_b_count !== 16'd5) begin
      errors++;
      $display("FAIL mid_run_counts got %0d/%0d/%0d exp 5/5/5", cycle_count, stall_count, fwd_b_count);
    end
    reset = 1;
    step();
    checks++;
    if (cycle_count !== 0 || stall_count !== 0 || fwd_b_count !== 0 || core_reset !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_reset got cyc=%0d stall=%0d fb=%0d cr=%b run=%b exp 0/0/0/1/0",
               cycle_count, stall_count, fwd_b_count, core_reset, running);
    end
    reset = 0;
    idle_inputs();
    step();
    checks++;
    if (running !== 1'b1 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL restart_entry got run=%b cr=%b exp 1/0", running, core_reset);
    end
    for (int i = 1; i <= 2; i++) begin
      pc_ex = 32'h500 + 32'(4 * i);
      step();
    end
    checks++;
    if (cycle_count !== 16'd2 || stall_count !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_count got cyc=%0d stall=%0d done=%b exp 2/0/0", cycle_count, stall_count, done);
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_timeout();
    test_events();
    test_halt();
    test_stalled_pc();
    test_halt_and_timeout();
    test_mid_run_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
